ifu_mem_sched: RTL and testbench

IFU_MEM_SCHED -- requirements
Module: ifu_mem_sched

---
 rtl/ifu_mem_sched.sv | 116 +++++++++++
 tb/tb_ifu_mem_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_mem_sched.sv
// Instruction-fetch memory scheduler: arbitrates demand and prefetch line
// requests onto a single-outstanding memory port, with timeout reissue.
module ifu_mem_sched #(
    parameter int unsigned TAG_WIDTH      = 27,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
    input  logic                  cache_reqValidIn,
    output logic                  cache_reqAckOut,
    input  logic [TAG_WIDTH-1:0]  pf_reqTagIn,
    input  logic                  pf_reqValidIn,
    output logic                  pf_reqAckOut,
    output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
    output logic                  mem_reqValidOut,
    input  logic                  mem_reqReadyIn,
    input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
    input  logic                  mem_rspValidIn,
    output logic [TAG_WIDTH-1:0]  fill_tagOut,
    output logic [LINE_WIDTH-1:0] fill_lineOut,
    output logic                  fill_validOut,
    output logic                  fill_isPrefetchOut,
    output logic                  busyOut,
    output logic [7:0]            timeoutCntOut
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FILL} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    logic [TAG_WIDTH-1:0]  cur_tag_q;
    logic                  cur_is_pf_q;
    logic [7:0]            tmo_q;
    logic [7:0]            reissue_q;
    logic [LINE_WIDTH-1:0] line_q;

    logic rsp_hit;
    logic merge;
    logic pf_drop;

    always_comb begin
        rsp_hit = mem_rspValidIn && (mem_rspTagIn == cur_tag_q);
        merge   = ((state_q == ISSUE) || (state_q == WAIT)) && cache_reqValidIn &&
                  (cache_reqTagIn == cur_tag_q) && cur_is_pf_q;
        pf_drop = (state_q != IDLE) && pf_reqValidIn && (pf_reqTagIn == cur_tag_q);
    end

    // Acks are decoded in the acceptance cycle so a held request is never
    // seen again by the merge/drop compare after it has been taken.
    always_comb begin
        cache_reqAckOut = ((state_q == IDLE) && cache_reqValidIn) || merge;
        pf_reqAckOut    = ((state_q == IDLE) && !cache_reqValidIn && pf_reqValidIn) || pf_drop;
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            cur_tag_q   <= '0;
            cur_is_pf_q <= 1'b0;
            tmo_q       <= '0;
            reissue_q   <= '0;
            line_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cache_reqValidIn) begin
                        cur_tag_q   <= cache_reqTagIn;
                        cur_is_pf_q <= 1'b0;
                        state_q     <= ISSUE;
                    end else if (pf_reqValidIn) begin
                        cur_tag_q   <= pf_reqTagIn;
                        cur_is_pf_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (merge) cur_is_pf_q <= 1'b0;
                    if (mem_reqReadyIn) begin
                        tmo_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (merge) cur_is_pf_q <= 1'b0;
                    if (rsp_hit) begin
                        line_q  <= mem_rspInsLineIn;
                        state_q <= FILL;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ISSUE;
                        if (reissue_q != 8'hFF) reissue_q <= reissue_q + 8'd1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                FILL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_reqValidOut    = (state_q == ISSUE);
        mem_reqTagOut      = cur_tag_q;
        fill_validOut      = (state_q == FILL);
        fill_tagOut        = cur_tag_q;
        fill_lineOut       = line_q;
        fill_isPrefetchOut = (state_q == FILL) && cur_is_pf_q;
        busyOut            = (state_q != IDLE);
        timeoutCntOut      = reissue_q;
    end

endmodule

// File: tb/tb_ifu_mem_sched.sv
// Directed, table-driven bench for ifu_mem_sched with TIMEOUT_CYCLES=4;
// multi-cycle corners (timeout, stall, mid-flight reset) are hand-sequenced.
module tb_ifu_mem_sched;

    localparam int TW = 27;
    localparam int LW = 128;

    logic          Clock = 1'b0;
    logic          Rst   = 1'b1;
    logic [TW-1:0] cache_reqTagIn   = '0;
    logic          cache_reqValidIn = 1'b0;
    logic          cache_reqAckOut;
    logic [TW-1:0] pf_reqTagIn      = '0;
    logic          pf_reqValidIn    = 1'b0;
    logic          pf_reqAckOut;
    logic [TW-1:0] mem_reqTagOut;
    logic          mem_reqValidOut;
    logic          mem_reqReadyIn   = 1'b0;
    logic [TW-1:0] mem_rspTagIn     = '0;
    logic [LW-1:0] mem_rspInsLineIn = '0;
    logic          mem_rspValidIn   = 1'b0;
    logic [TW-1:0] fill_tagOut;
    logic [LW-1:0] fill_lineOut;
    logic          fill_validOut;
    logic          fill_isPrefetchOut;
    logic          busyOut;
    logic [7:0]    timeoutCntOut;

    int n_vec = 0;
    int n_err = 0;

    ifu_mem_sched #(.TAG_WIDTH(TW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(4)) dut (
        .Clock             (Clock),
        .Rst               (Rst),
        .cache_reqTagIn    (cache_reqTagIn),
        .cache_reqValidIn  (cache_reqValidIn),
        .cache_reqAckOut   (cache_reqAckOut),
        .pf_reqTagIn       (pf_reqTagIn),
        .pf_reqValidIn     (pf_reqValidIn),
        .pf_reqAckOut      (pf_reqAckOut),
        .mem_reqTagOut     (mem_reqTagOut),
        .mem_reqValidOut   (mem_reqValidOut),
        .mem_reqReadyIn    (mem_reqReadyIn),
        .mem_rspTagIn      (mem_rspTagIn),
        .mem_rspInsLineIn  (mem_rspInsLineIn),
        .mem_rspValidIn    (mem_rspValidIn),
        .fill_tagOut       (fill_tagOut),
        .fill_lineOut      (fill_lineOut),
        .fill_validOut     (fill_validOut),
        .fill_isPrefetchOut(fill_isPrefetchOut),
        .busyOut           (busyOut),
        .timeoutCntOut     (timeoutCntOut)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string         name;
        logic          rst;
        logic          cv;
        logic [TW-1:0] ct;
        logic          pv;
        logic [TW-1:0] pt;
        logic          rdy;
        logic          rv;
        logic [TW-1:0] rt;
        logic          ca;
        logic          pa;
        logic          mv;
        logic [TW-1:0] mt;
        logic          fv;
        logic [TW-1:0] ft;
        logic          fp;
        logic          bz;
        logic [7:0]    tc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [LW-1:0] line_of(input logic [TW-1:0] t);
        return {4{32'hA500_0000 | 32'(t)}};
    endfunction

    function automatic vec_t mk(input string name, input bit rst,
                                input bit cv, input int ct, input bit pv, input int pt,
                                input bit rdy, input bit rv, input int rt,
                                input bit ca, input bit pa, input bit mv, input int mt,
                                input bit fv, input int ft, input bit fp,
                                input bit bz, input int tc);
        vec_t v;
        v.name = name; v.rst = rst;
        v.cv = cv; v.ct = TW'(ct); v.pv = pv; v.pt = TW'(pt);
        v.rdy = rdy; v.rv = rv; v.rt = TW'(rt);
        v.ca = ca; v.pa = pa; v.mv = mv; v.mt = TW'(mt);
        v.fv = fv; v.ft = TW'(ft); v.fp = fp; v.bz = bz; v.tc = 8'(tc);
        return v;
    endfunction

    task automatic drive(input logic cv, input logic [TW-1:0] ct,
                         input logic pv, input logic [TW-1:0] pt,
                         input logic rdy, input logic rv, input logic [TW-1:0] rt);
        cache_reqValidIn = cv;
        cache_reqTagIn   = ct;
        pf_reqValidIn    = pv;
        pf_reqTagIn      = pt;
        mem_reqReadyIn   = rdy;
        mem_rspValidIn   = rv;
        mem_rspTagIn     = rt;
        mem_rspInsLineIn = rv ? line_of(rt) : '0;
    endtask

    task automatic cyc(input logic cv, input logic [TW-1:0] ct,
                       input logic pv, input logic [TW-1:0] pt,
                       input logic rdy, input logic rv, input logic [TW-1:0] rt);
        @(negedge Clock);
        drive(cv, ct, pv, pt, rdy, rv, rt);
        #1;
    endtask

    task automatic check(input string name, input logic ca, input logic pa,
                         input logic mv, input logic [TW-1:0] mt,
                         input logic fv, input logic [TW-1:0] ft, input logic fp,
                         input logic bz, input logic [7:0] tc);
        logic ok;
        ok = (cache_reqAckOut === ca) && (pf_reqAckOut === pa) &&
             (mem_reqValidOut === mv) && (fill_validOut === fv) &&
             (fill_isPrefetchOut === fp) && (busyOut === bz) && (timeoutCntOut === tc);
        if (mv) ok = ok && (mem_reqTagOut === mt);
        if (fv) ok = ok && (fill_tagOut === ft) && (fill_lineOut === line_of(ft));
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got ca=%b pa=%b mv=%b mt=%h fv=%b ft=%h fp=%b busy=%b tc=%0d line=%h; want ca=%b pa=%b mv=%b mt=%h fv=%b ft=%h fp=%b busy=%b tc=%0d",
                     name, cache_reqAckOut, pf_reqAckOut, mem_reqValidOut, mem_reqTagOut,
                     fill_validOut, fill_tagOut, fill_isPrefetchOut, busyOut, timeoutCntOut,
                     fill_lineOut, ca, pa, mv, mt, fv, ft, fp, bz, tc);
        end
    endtask

    initial begin
        //                name            rst cv ct     pv pt     rdy rv rt       ca pa mv mt      fv ft     fp bz tc
        vecs.push_back(mk("rst",           1, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("dmd_ack",       0, 1, 'h12,  0, 0,     0,  0, 0,       1, 0, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("dmd_issue",     0, 0, 0,     0, 0,     1,  0, 0,       0, 0, 1, 'h12,   0, 0,     0, 1, 0));
        vecs.push_back(mk("dmd_wait",      0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("dmd_rsp",       0, 0, 0,     0, 0,     0,  1, 'h12,    0, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("dmd_fill",      0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      1, 'h12,  0, 1, 0));
        vecs.push_back(mk("dmd_idle",      0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("prio_ack",      0, 1, 5,     1, 9,     0,  0, 0,       1, 0, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("prio_issue",    0, 0, 0,     1, 9,     1,  0, 0,       0, 0, 1, 5,      0, 0,     0, 1, 0));
        vecs.push_back(mk("prio_rsp",      0, 0, 0,     1, 9,     0,  1, 5,       0, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("prio_fill",     0, 0, 0,     1, 9,     0,  0, 0,       0, 0, 0, 0,      1, 5,     0, 1, 0));
        vecs.push_back(mk("pf_ack",        0, 0, 0,     1, 9,     0,  0, 0,       0, 1, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("pf_issue",      0, 0, 0,     0, 0,     1,  0, 0,       0, 0, 1, 9,      0, 0,     0, 1, 0));
        vecs.push_back(mk("pf_rsp",        0, 0, 0,     0, 0,     0,  1, 9,       0, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("pf_fill",       0, 0, 0,     1, 7,     0,  0, 0,       0, 0, 0, 0,      1, 9,     1, 1, 0));
        vecs.push_back(mk("b2b_ack",       0, 0, 0,     1, 7,     0,  0, 0,       0, 1, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("mrg_issue",     0, 0, 0,     0, 0,     1,  0, 0,       0, 0, 1, 7,      0, 0,     0, 1, 0));
        vecs.push_back(mk("mrg_wait",      0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("mrg_ack",       0, 1, 7,     0, 0,     0,  0, 0,       1, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("mrg_rsp",       0, 0, 0,     0, 0,     0,  1, 7,       0, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("mrg_fill",      0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      1, 7,     0, 1, 0));
        vecs.push_back(mk("drop_ack",      0, 0, 0,     1, 'hA,   0,  0, 0,       0, 1, 0, 0,      0, 0,     0, 0, 0));
        vecs.push_back(mk("drop_dup",      0, 0, 0,     1, 'hA,   0,  0, 0,       0, 1, 1, 'hA,    0, 0,     0, 1, 0));
        vecs.push_back(mk("drop_issue",    0, 0, 0,     0, 0,     1,  0, 0,       0, 0, 1, 'hA,    0, 0,     0, 1, 0));
        vecs.push_back(mk("mrg_rsp_same",  0, 1, 'hA,  0, 0,     0,  1, 'hA,     1, 0, 0, 0,      0, 0,     0, 1, 0));
        vecs.push_back(mk("same_fill",     0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      1, 'hA,   0, 1, 0));
        vecs.push_back(mk("same_idle",     0, 0, 0,     0, 0,     0,  0, 0,       0, 0, 0, 0,      0, 0,     0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge Clock);
            Rst = vecs[i].rst;
            drive(vecs[i].cv, vecs[i].ct, vecs[i].pv, vecs[i].pt,
                  vecs[i].rdy, vecs[i].rv, vecs[i].rt);
            #1;
            check(vecs[i].name, vecs[i].ca, vecs[i].pa, vecs[i].mv, vecs[i].mt,
                  vecs[i].fv, vecs[i].ft, vecs[i].fp, vecs[i].bz, vecs[i].tc);
        end

        // Timeout reissue after 4 WAIT cycles, with a stray response ignored.
        cyc(1, 4, 0, 0, 0, 0, 0);  check("to_ack",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);  check("to_issue",    0, 0, 1, 4, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, (i == 1), 3);
            check("to_wait",  0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);  check("to_reissue",  0, 0, 1, 4, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);  check("to_accept",   0, 0, 1, 4, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 4);  check("to_rsp",      0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);  check("to_fill",     0, 0, 0, 0, 1, 4, 0, 1, 1);

        // Memory not ready for 10 cycles: request held, no timeout counted.
        cyc(1, 'h33, 0, 0, 0, 0, 0);  check("st_ack",   1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            check("st_hold", 0, 0, 1, 'h33, 0, 0, 0, 1, 1);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);  check("st_accept",   0, 0, 1, 'h33, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);  check("rw_wait",     0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Reset during WAIT: outputs clear at once, late response ignored.
        @(negedge Clock);
        Rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 'h33);
        #1;
        check("rw_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        Rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 'h33);
        #1;
        check("rw_stray", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);     check("rw_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 'h44, 0, 0, 0, 0, 0);  check("rw_ack",   1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);     check("rw_issue", 0, 0, 1, 'h44, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 'h44);  check("rw_rsp",   0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);     check("rw_fill",  0, 0, 0, 0, 1, 'h44, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);     check("rw_done",  0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
